// File: rtl/leaf_local_port.sv
// PE-side endpoint of a leaf router LOCAL port: a first-word fall-through receive FIFO
// that returns one credit per consumed flit, and a credit-gated transmit register.
module leaf_local_port #(
  parameter int WIDTH      = 64,
  parameter int RX_DEPTH   = 4,
  parameter int TX_CREDITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_data_valid,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            upstream_credit,
  output logic                            out_data_valid,
  output logic [WIDTH-1:0]                out_data,
  input  logic                            downstream_credit,
  output logic                            rx_valid,
  output logic [WIDTH-1:0]                rx_data,
  input  logic                            rx_ready,
  input  logic                            tx_valid,
  input  logic [WIDTH-1:0]                tx_data,
  output logic                            tx_ready,
  output logic [$clog2(TX_CREDITS+1)-1:0] tx_credit_cnt,
  output logic                            rx_overflow,
  output logic                            credit_err
);

  localparam int PW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW  = $clog2(RX_DEPTH + 1);
  localparam int TCW = $clog2(TX_CREDITS + 1);

  logic [WIDTH-1:0] mem [RX_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    rx_count;
  logic             rx_full, rx_pop, rx_wr;
  logic             tx_hs;

  assign rx_full  = (rx_count == CW'(RX_DEPTH));
  assign rx_valid = (rx_count != '0);
  assign rx_data  = mem[rd_ptr];
  assign rx_pop   = rx_valid & rx_ready;
  // A push into a full FIFO is still accepted when the head is leaving the same cycle.
  assign rx_wr    = in_data_valid & (~rx_full | rx_pop);

  assign tx_ready = (tx_credit_cnt != '0);
  assign tx_hs    = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      rx_count        <= '0;
      rx_overflow     <= 1'b0;
      upstream_credit <= 1'b0;
    end else begin
      if (rx_wr) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rx_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({rx_wr, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
      if (in_data_valid && rx_full && !rx_pop) rx_overflow <= 1'b1;
      upstream_credit <= rx_pop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_valid <= 1'b0;
      out_data       <= '0;
      tx_credit_cnt  <= TCW'(TX_CREDITS);
      credit_err     <= 1'b0;
    end else begin
      out_data_valid <= tx_hs;
      if (tx_hs) out_data <= tx_data;
      case ({tx_hs, downstream_credit})
        2'b10: tx_credit_cnt <= tx_credit_cnt - TCW'(1);
        2'b01: begin
          // Surplus credit saturates the counter and latches the error.
          if (tx_credit_cnt == TCW'(TX_CREDITS)) credit_err <= 1'b1;
          else                                  tx_credit_cnt <= tx_credit_cnt + TCW'(1);
        end
        default: tx_credit_cnt <= tx_credit_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_local_port.sv
// Directed vector bench for leaf_local_port: per-cycle stimulus with expected post-edge outputs.
module tb_leaf_local_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_data_valid, rx_ready, tx_valid, downstream_credit;
  logic [63:0] in_data, tx_data;
  logic        upstream_credit, out_data_valid, rx_valid, tx_ready, rx_overflow, credit_err;
  logic [63:0] out_data, rx_data;
  logic [2:0]  tx_credit_cnt;

  leaf_local_port #(.WIDTH(64), .RX_DEPTH(4), .TX_CREDITS(4)) dut (
    .clk(clk), .rst(rst),
    .in_data_valid(in_data_valid), .in_data(in_data),
    .upstream_credit(upstream_credit),
    .out_data_valid(out_data_valid), .out_data(out_data),
    .downstream_credit(downstream_credit),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_credit_cnt(tx_credit_cnt),
    .rx_overflow(rx_overflow), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        rr;
    logic        tv;
    logic [63:0] td;
    logic        dc;
    logic        e_rv;
    logic [63:0] e_rd;
    logic        e_uc;
    logic        e_ov;
    logic [63:0] e_od;
    logic        e_tr;
    logic [2:0]  e_cnt;
    logic        e_rovf;
    logic        e_cerr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic iv, input logic [63:0] id, input logic rr,
                     input logic tv, input logic [63:0] td, input logic dc,
                     input logic e_rv, input logic [63:0] e_rd, input logic e_uc,
                     input logic e_ov, input logic [63:0] e_od, input logic e_tr,
                     input logic [2:0] e_cnt, input logic e_rovf, input logic e_cerr);
    vec_t v;
    v.iv = iv; v.id = id; v.rr = rr; v.tv = tv; v.td = td; v.dc = dc;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_uc = e_uc; v.e_ov = e_ov; v.e_od = e_od;
    v.e_tr = e_tr; v.e_cnt = e_cnt; v.e_rovf = e_rovf; v.e_cerr = e_cerr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input vec_t v);
    bit bad = 0;
    n_vec++;
    if (rx_valid !== v.e_rv)       begin bad = 1; $display("FAIL %s rx_valid got %b want %b", name, rx_valid, v.e_rv); end
    if (rx_data !== v.e_rd)        begin bad = 1; $display("FAIL %s rx_data got %h want %h", name, rx_data, v.e_rd); end
    if (upstream_credit !== v.e_uc) begin bad = 1; $display("FAIL %s upstream_credit got %b want %b", name, upstream_credit, v.e_uc); end
    if (out_data_valid !== v.e_ov) begin bad = 1; $display("FAIL %s out_data_valid got %b want %b", name, out_data_valid, v.e_ov); end
    if (out_data !== v.e_od)       begin bad = 1; $display("FAIL %s out_data got %h want %h", name, out_data, v.e_od); end
    if (tx_ready !== v.e_tr)       begin bad = 1; $display("FAIL %s tx_ready got %b want %b", name, tx_ready, v.e_tr); end
    if (tx_credit_cnt !== v.e_cnt) begin bad = 1; $display("FAIL %s tx_credit_cnt got %0d want %0d", name, tx_credit_cnt, v.e_cnt); end
    if (rx_overflow !== v.e_rovf)  begin bad = 1; $display("FAIL %s rx_overflow got %b want %b", name, rx_overflow, v.e_rovf); end
    if (credit_err !== v.e_cerr)   begin bad = 1; $display("FAIL %s credit_err got %b want %b", name, credit_err, v.e_cerr); end
    if (bad) n_bad++;
  endtask

  task automatic drive(input vec_t v);
    in_data_valid = v.iv; in_data = v.id; rx_ready = v.rr;
    tx_valid = v.tv; tx_data = v.td; downstream_credit = v.dc;
  endtask

  function automatic vec_t idle_exp(input logic rv, input logic [63:0] rd, input logic [63:0] od,
                                    input logic [2:0] cnt, input logic rovf, input logic cerr);
    vec_t v;
    v.iv = 0; v.id = '0; v.rr = 0; v.tv = 0; v.td = '0; v.dc = 0;
    v.e_rv = rv; v.e_rd = rd; v.e_uc = 0; v.e_ov = 0; v.e_od = od;
    v.e_tr = (cnt != 0); v.e_cnt = cnt; v.e_rovf = rovf; v.e_cerr = cerr;
    return v;
  endfunction

  initial begin
    vec_t v;
    //   iv id     rr tv td     dc | rv rd     uc ov od     tr cnt ovf cerr
    // RX fill with rx_ready low
    add(1, 64'h11, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    add(1, 64'h22, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    add(1, 64'h33, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    add(1, 64'h44, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    // drain: one credit pulse the cycle after each pop
    add(0, 64'h0,  1, 0, 64'h0, 0,  1, 64'h22, 1, 0, 64'h0, 1, 4, 0, 0);
    add(0, 64'h0,  1, 0, 64'h0, 0,  1, 64'h33, 1, 0, 64'h0, 1, 4, 0, 0);
    add(0, 64'h0,  1, 0, 64'h0, 0,  1, 64'h44, 1, 0, 64'h0, 1, 4, 0, 0);
    add(0, 64'h0,  1, 0, 64'h0, 0,  0, 64'h11, 1, 0, 64'h0, 1, 4, 0, 0);
    add(0, 64'h0,  0, 0, 64'h0, 0,  0, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    // refill, then push into full FIFO with simultaneous pop
    add(1, 64'h11, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    add(1, 64'h22, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    add(1, 64'h33, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    add(1, 64'h44, 0, 0, 64'h0, 0,  1, 64'h11, 0, 0, 64'h0, 1, 4, 0, 0);
    add(1, 64'h55, 1, 0, 64'h0, 0,  1, 64'h22, 1, 0, 64'h0, 1, 4, 0, 0);
    add(0, 64'h0,  0, 0, 64'h0, 0,  1, 64'h22, 0, 0, 64'h0, 1, 4, 0, 0);
    // push into full FIFO with no pop: dropped, overflow sticky
    add(1, 64'h66, 0, 0, 64'h0, 0,  1, 64'h22, 0, 0, 64'h0, 1, 4, 1, 0);
    add(0, 64'h0,  1, 0, 64'h0, 0,  1, 64'h33, 1, 0, 64'h0, 1, 4, 1, 0);
    add(0, 64'h0,  1, 0, 64'h0, 0,  1, 64'h44, 1, 0, 64'h0, 1, 4, 1, 0);
    add(0, 64'h0,  1, 0, 64'h0, 0,  1, 64'h55, 1, 0, 64'h0, 1, 4, 1, 0);
    add(0, 64'h0,  1, 0, 64'h0, 0,  0, 64'h22, 1, 0, 64'h0, 1, 4, 1, 0);
    add(0, 64'h0,  0, 0, 64'h0, 0,  0, 64'h22, 0, 0, 64'h0, 1, 4, 1, 0);
    // TX credit exhaustion
    add(0, 64'h0,  0, 1, 64'hA0, 0, 0, 64'h22, 0, 1, 64'hA0, 1, 3, 1, 0);
    add(0, 64'h0,  0, 1, 64'hA1, 0, 0, 64'h22, 0, 1, 64'hA1, 1, 2, 1, 0);
    add(0, 64'h0,  0, 1, 64'hA2, 0, 0, 64'h22, 0, 1, 64'hA2, 1, 1, 1, 0);
    add(0, 64'h0,  0, 1, 64'hA3, 0, 0, 64'h22, 0, 1, 64'hA3, 0, 0, 1, 0);
    add(0, 64'h0,  0, 1, 64'hA4, 0, 0, 64'h22, 0, 0, 64'hA3, 0, 0, 1, 0);
    add(0, 64'h0,  0, 1, 64'hA4, 0, 0, 64'h22, 0, 0, 64'hA3, 0, 0, 1, 0);
    // recovery from zero credits
    add(0, 64'h0,  0, 1, 64'hA4, 1, 0, 64'h22, 0, 0, 64'hA3, 1, 1, 1, 0);
    add(0, 64'h0,  0, 1, 64'hA4, 0, 0, 64'h22, 0, 1, 64'hA4, 0, 0, 1, 0);
    add(0, 64'h0,  0, 0, 64'h0,  0, 0, 64'h22, 0, 0, 64'hA4, 0, 0, 1, 0);
    // handshake plus credit at count 2, then saturation
    add(0, 64'h0,  0, 0, 64'h0,  1, 0, 64'h22, 0, 0, 64'hA4, 1, 1, 1, 0);
    add(0, 64'h0,  0, 0, 64'h0,  1, 0, 64'h22, 0, 0, 64'hA4, 1, 2, 1, 0);
    add(0, 64'h0,  0, 1, 64'hB0, 1, 0, 64'h22, 0, 1, 64'hB0, 1, 2, 1, 0);
    add(0, 64'h0,  0, 0, 64'h0,  1, 0, 64'h22, 0, 0, 64'hB0, 1, 3, 1, 0);
    add(0, 64'h0,  0, 0, 64'h0,  1, 0, 64'h22, 0, 0, 64'hB0, 1, 4, 1, 0);
    add(0, 64'h0,  0, 0, 64'h0,  1, 0, 64'h22, 0, 0, 64'hB0, 1, 4, 1, 1);
    add(0, 64'h0,  0, 0, 64'h0,  0, 0, 64'h22, 0, 0, 64'hB0, 1, 4, 1, 1);
    // all ports active together
    add(1, 64'h88, 0, 1, 64'hC0, 1, 1, 64'h88, 0, 1, 64'hC0, 1, 4, 1, 1);
    add(1, 64'h99, 1, 1, 64'hC1, 0, 1, 64'h99, 1, 1, 64'hC1, 1, 3, 1, 1);

    rst = 1'b0;
    drive(idle_exp(0, '0, '0, 4, 0, 0));
    repeat (2) @(posedge clk);
    #1 check("in_reset", idle_exp(0, '0, '0, 4, 0, 0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("reset_release", idle_exp(0, '0, '0, 4, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // mid-burst async reset: keep pushing/sending, drop rst between edges
    v = vecs[vecs.size()-1];
    v.iv = 1; v.id = 64'hAA; v.rr = 0; v.tv = 1; v.td = 64'hC2; v.dc = 0;
    drive(v);
    @(negedge clk) rst = 1'b0;
    #1 check("async_reset", idle_exp(0, '0, '0, 4, 0, 0));
    @(posedge clk); #1;
    check("held_reset", idle_exp(0, '0, '0, 4, 0, 0));
    drive(idle_exp(0, '0, '0, 4, 0, 0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("after_reset", idle_exp(0, '0, '0, 4, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
